// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-lite SRAM responder:
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - write-channel and read-channel FSM state encodings
//   - seed for the optional random back-pressure LFSR
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_VALID = 2'd2
    } r_state_e;

endpackage : axi_lite_pkg

// File: rtl/axi_sram_array.sv
// ---------------------------------------------------------------------------
// axi_sram_array
// Word-addressed SRAM model with a byte-strobed synchronous write port and a
// combinational read port. When the read index equals the write index while
// a write is enabled, the read port returns the strobed new bytes merged with
// the old word (write-first bypass), so a sample taken on the same edge as
// the commit sees the new data.
//
// Ports:
//   clk        in   clock (the array has no reset)
//   we_i       in   write enable for this cycle
//   wr_idx_i   in   write word index
//   wr_data_i  in   write data, lane-aligned
//   wr_strb_i  in   byte-lane write enables
//   rd_idx_i   in   read word index
//   rd_data_o  out  read data (combinational, with bypass)
// ---------------------------------------------------------------------------
module axi_sram_array #(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024,
    parameter int IDX_W      = $clog2(MEM_DEPTH),
    parameter int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [STRB_W-1:0]     wr_strb_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // NOTE: the storage array is deliberately left out of reset; clearing
    // every word would need a reset fan-out to the whole array and contents
    // are expected to survive a reset anyway.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb_i[i]) begin
                    mem_q[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
                end
            end
        end
    end

    // NOTE: the output gets a full default before any conditional override,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_data_o = mem_q[rd_idx_i];
        if (we_i && (wr_idx_i == rd_idx_i)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb_i[i]) begin
                    rd_data_o[8*i +: 8] = wr_data_i[8*i +: 8];
                end
            end
        end
    end

endmodule : axi_sram_array

// File: rtl/axi_lite_sram_responder.sv
// ---------------------------------------------------------------------------
// axi_lite_sram_responder
// AXI4-lite-style subordinate serving the LSU read and write channels from an
// on-chip SRAM model. Independent write (AW/W/B) and read (AR/R) FSMs run
// concurrently; read latency from AR handshake to r_valid is RD_LATENCY.
// Addresses outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*bytes) get DECERR;
// out-of-range writes do not touch the array, out-of-range reads return 0.
//
// Ports (clk, rst async active-high, s_axi_* AXI4-lite subordinate):
//   AW: s_axi_aw_valid/ready/addr    W: s_axi_w_valid/ready/data/strb
//   B : s_axi_b_valid/ready/resp     AR: s_axi_ar_valid/ready/addr
//   R : s_axi_r_valid/ready/data/resp
//
// Build option: define AXI_SLAVE_RAND_BACKPRESSURE_EN to gate aw/w/ar ready
// with bits 0/1/2 of a free-running 16-bit LFSR (response valids unaffected).
// ---------------------------------------------------------------------------
module axi_lite_sram_responder
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(64'h8000_0000),
    parameter int                    RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axi_aw_valid,
    output logic                    s_axi_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_aw_addr,
    input  logic                    s_axi_w_valid,
    output logic                    s_axi_w_ready,
    input  logic [DATA_WIDTH-1:0]   s_axi_w_data,
    input  logic [DATA_WIDTH/8-1:0] s_axi_w_strb,
    output logic                    s_axi_b_valid,
    input  logic                    s_axi_b_ready,
    output logic [1:0]              s_axi_b_resp,
    input  logic                    s_axi_ar_valid,
    output logic                    s_axi_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_ar_addr,
    output logic                    s_axi_r_valid,
    input  logic                    s_axi_r_ready,
    output logic [DATA_WIDTH-1:0]   s_axi_r_data,
    output logic [1:0]              s_axi_r_resp
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int CNT_W  = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_DEPTH * STRB_W);

    // ---------------- ready gating ----------------
    logic aw_gate, w_gate, ar_gate;

`ifdef AXI_SLAVE_RAND_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign aw_gate = lfsr_q[0];
    assign w_gate  = lfsr_q[1];
    assign ar_gate = lfsr_q[2];
`else
    assign aw_gate = 1'b1;
    assign w_gate  = 1'b1;
    assign ar_gate = 1'b1;
`endif

    // ---------------- state ----------------
    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [1:0]            b_resp_q,  b_resp_d;

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [CNT_W-1:0]      rd_cnt_q,  rd_cnt_d;
    logic [DATA_WIDTH-1:0] r_data_q,  r_data_d;
    logic [1:0]            r_resp_q,  r_resp_d;

    // ---------------- address decode ----------------
    logic [ADDR_WIDTH-1:0] wr_offset, rd_addr, rd_offset;
    logic                  wr_in_range, rd_in_range;
    logic [IDX_W-1:0]      wr_index, rd_index;

    // In R_IDLE the sample may happen on the AR handshake edge itself
    // (RD_LATENCY == 1), so the live bus address is decoded there.
    assign rd_addr     = (r_state_q == R_IDLE) ? s_axi_ar_addr : ar_addr_q;

    assign wr_offset   = aw_addr_q - BASE_ADDR;
    assign rd_offset   = rd_addr - BASE_ADDR;
    assign wr_in_range = (aw_addr_q >= BASE_ADDR) && (wr_offset < SPAN);
    assign rd_in_range = (rd_addr >= BASE_ADDR) && (rd_offset < SPAN);
    assign wr_index    = wr_offset[OFF_W +: IDX_W];
    assign rd_index    = rd_offset[OFF_W +: IDX_W];

    // ---------------- memory ----------------
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    axi_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W),
        .STRB_W     (STRB_W)
    ) u_array (
        .clk       (clk),
        .we_i      (mem_we),
        .wr_idx_i  (wr_index),
        .wr_data_i (s_axi_w_data),
        .wr_strb_i (s_axi_w_strb),
        .rd_idx_i  (rd_index),
        .rd_data_o (mem_rd_data)
    );

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            b_resp_q  <= b_resp_d;
        end
    end

    always_comb begin
        w_state_d      = w_state_q;
        aw_addr_d      = aw_addr_q;
        b_resp_d       = b_resp_q;
        s_axi_aw_ready = 1'b0;
        s_axi_w_ready  = 1'b0;
        s_axi_b_valid  = 1'b0;
        mem_we         = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_axi_aw_ready = aw_gate;
                if (s_axi_aw_valid && aw_gate) begin
                    aw_addr_d = s_axi_aw_addr;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_w_ready = w_gate;
                if (s_axi_w_valid && w_gate) begin
                    mem_we    = wr_in_range;
                    b_resp_d  = wr_in_range ? RESP_OKAY : RESP_DECERR;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_b_valid = 1'b1;
                if (s_axi_b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign s_axi_b_resp = b_resp_q;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            rd_cnt_q  <= '0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            ar_addr_q <= ar_addr_d;
            rd_cnt_q  <= rd_cnt_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
        end
    end

    always_comb begin
        logic load_rdata;
        load_rdata     = 1'b0;
        r_state_d      = r_state_q;
        ar_addr_d      = ar_addr_q;
        rd_cnt_d       = rd_cnt_q;
        r_data_d       = r_data_q;
        r_resp_d       = r_resp_q;
        s_axi_ar_ready = 1'b0;
        s_axi_r_valid  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_axi_ar_ready = ar_gate;
                if (s_axi_ar_valid && ar_gate) begin
                    ar_addr_d = s_axi_ar_addr;
                    if (RD_LATENCY == 1) begin
                        load_rdata = 1'b1;
                        r_state_d  = R_VALID;
                    end else begin
                        // Remaining wait cycles after the handshake cycle.
                        rd_cnt_d  = CNT_W'(RD_LATENCY - 1);
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt_q <= CNT_W'(1)) begin
                    load_rdata = 1'b1;
                    r_state_d  = R_VALID;
                end else begin
                    rd_cnt_d = rd_cnt_q - CNT_W'(1);
                end
            end
            R_VALID: begin
                s_axi_r_valid = 1'b1;
                if (s_axi_r_ready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        if (load_rdata) begin
            r_data_d = rd_in_range ? mem_rd_data : '0;
            r_resp_d = rd_in_range ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign s_axi_r_data = r_data_q;
    assign s_axi_r_resp = r_resp_q;

endmodule : axi_lite_sram_responder

// File: tb/tb_axi_lite_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_sram_responder
// Directed and randomized checks of axi_lite_sram_responder (RD_LATENCY = 2)
// against a word-array model of the SRAM held in the bench.
// ---------------------------------------------------------------------------
module tb_axi_lite_sram_responder;

    localparam int          RD_LAT = 2;
    localparam int          DEPTH  = 1024;
    localparam logic [63:0] BASE   = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_axi_aw_valid, s_axi_aw_ready;
    logic [63:0] s_axi_aw_addr;
    logic        s_axi_w_valid, s_axi_w_ready;
    logic [63:0] s_axi_w_data;
    logic [7:0]  s_axi_w_strb;
    logic        s_axi_b_valid, s_axi_b_ready;
    logic [1:0]  s_axi_b_resp;
    logic        s_axi_ar_valid, s_axi_ar_ready;
    logic [63:0] s_axi_ar_addr;
    logic        s_axi_r_valid, s_axi_r_ready;
    logic [63:0] s_axi_r_data;
    logic [1:0]  s_axi_r_resp;

    int tests = 0;
    int fails = 0;

    logic [63:0] mdl_mem [DEPTH];

    always #5 clk = ~clk;

    axi_lite_sram_responder #(
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axi_aw_valid (s_axi_aw_valid),
        .s_axi_aw_ready (s_axi_aw_ready),
        .s_axi_aw_addr  (s_axi_aw_addr),
        .s_axi_w_valid  (s_axi_w_valid),
        .s_axi_w_ready  (s_axi_w_ready),
        .s_axi_w_data   (s_axi_w_data),
        .s_axi_w_strb   (s_axi_w_strb),
        .s_axi_b_valid  (s_axi_b_valid),
        .s_axi_b_ready  (s_axi_b_ready),
        .s_axi_b_resp   (s_axi_b_resp),
        .s_axi_ar_valid (s_axi_ar_valid),
        .s_axi_ar_ready (s_axi_ar_ready),
        .s_axi_ar_addr  (s_axi_ar_addr),
        .s_axi_r_valid  (s_axi_r_valid),
        .s_axi_r_ready  (s_axi_r_ready),
        .s_axi_r_data   (s_axi_r_data),
        .s_axi_r_resp   (s_axi_r_resp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit mdl_hit(input logic [63:0] addr);
        return (addr >= BASE) && (addr < BASE + 64'(DEPTH * 8));
    endfunction

    function automatic int mdl_idx(input logic [63:0] addr);
        return int'((addr - BASE) >> 3);
    endfunction

    function automatic logic [63:0] mdl_rdata(input logic [63:0] addr);
        return mdl_hit(addr) ? mdl_mem[mdl_idx(addr)] : 64'h0;
    endfunction

    function automatic logic [1:0] mdl_resp(input logic [63:0] addr);
        return mdl_hit(addr) ? 2'b00 : 2'b11;
    endfunction

    task automatic mdl_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        if (mdl_hit(addr)) begin
            for (int i = 0; i < 8; i++) begin
                if (strb[i]) mdl_mem[mdl_idx(addr)][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    // ---------------- bus tasks ----------------
    task automatic tb_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int hold, input string tag);
        logic [1:0] exp_resp;
        exp_resp       = mdl_resp(addr);
        s_axi_aw_addr  = addr;
        s_axi_aw_valid = 1'b1;
        for (int n = 0; n < 50 && !s_axi_aw_ready; n++) step();
        check({tag, ".aw_ready"}, 64'(s_axi_aw_ready), 64'd1);
        step();
        s_axi_aw_valid = 1'b0;
        s_axi_w_data   = data;
        s_axi_w_strb   = strb;
        s_axi_w_valid  = 1'b1;
        for (int n = 0; n < 50 && !s_axi_w_ready; n++) step();
        check({tag, ".w_ready"}, 64'(s_axi_w_ready), 64'd1);
        step();
        s_axi_w_valid = 1'b0;
        mdl_write(addr, data, strb);
        check({tag, ".b_valid"}, 64'(s_axi_b_valid), 64'd1);
        check({tag, ".b_resp"}, 64'(s_axi_b_resp), 64'(exp_resp));
        for (int c = 0; c < hold; c++) begin
            step();
            check({tag, ".hold_b_valid"}, 64'(s_axi_b_valid), 64'd1);
            check({tag, ".hold_b_resp"}, 64'(s_axi_b_resp), 64'(exp_resp));
            check({tag, ".hold_aw_ready"}, 64'(s_axi_aw_ready), 64'd0);
        end
        s_axi_b_ready = 1'b1;
        step();
        s_axi_b_ready = 1'b0;
        check({tag, ".b_done"}, 64'(s_axi_b_valid), 64'd0);
    endtask

    task automatic tb_read(input logic [63:0] addr, input int hold, input string tag);
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        int          lat;
        exp_data       = mdl_rdata(addr);
        exp_resp       = mdl_resp(addr);
        s_axi_ar_addr  = addr;
        s_axi_ar_valid = 1'b1;
        for (int n = 0; n < 50 && !s_axi_ar_ready; n++) step();
        check({tag, ".ar_ready"}, 64'(s_axi_ar_ready), 64'd1);
        step();
        s_axi_ar_valid = 1'b0;
        lat = 1;
        for (int n = 0; n < 20 && !s_axi_r_valid; n++) begin
            check({tag, ".wait_ar_ready"}, 64'(s_axi_ar_ready), 64'd0);
            step();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(RD_LAT));
        check({tag, ".r_data"}, s_axi_r_data, exp_data);
        check({tag, ".r_resp"}, 64'(s_axi_r_resp), 64'(exp_resp));
        for (int c = 0; c < hold; c++) begin
            step();
            check({tag, ".hold_r_valid"}, 64'(s_axi_r_valid), 64'd1);
            check({tag, ".hold_r_data"}, s_axi_r_data, exp_data);
            check({tag, ".hold_r_resp"}, 64'(s_axi_r_resp), 64'(exp_resp));
            check({tag, ".hold_ar_ready"}, 64'(s_axi_ar_ready), 64'd0);
        end
        s_axi_r_ready = 1'b1;
        step();
        s_axi_r_ready = 1'b0;
        check({tag, ".r_done"}, 64'(s_axi_r_valid), 64'd0);
        check({tag, ".ar_ready_back"}, 64'(s_axi_ar_ready), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] addr;
        int          sel;

        rst            = 1'b1;
        s_axi_aw_valid = 1'b0;
        s_axi_aw_addr  = '0;
        s_axi_w_valid  = 1'b0;
        s_axi_w_data   = '0;
        s_axi_w_strb   = '0;
        s_axi_b_ready  = 1'b0;
        s_axi_ar_valid = 1'b0;
        s_axi_ar_addr  = '0;
        s_axi_r_ready  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst.aw_ready", 64'(s_axi_aw_ready), 64'd1);
        check("rst.ar_ready", 64'(s_axi_ar_ready), 64'd1);
        check("rst.w_ready", 64'(s_axi_w_ready), 64'd0);
        check("rst.b_valid", 64'(s_axi_b_valid), 64'd0);
        check("rst.r_valid", 64'(s_axi_r_valid), 64'd0);
        check("rst.b_resp", 64'(s_axi_b_resp), 64'd0);
        check("rst.r_resp", 64'(s_axi_r_resp), 64'd0);
        check("rst.r_data", s_axi_r_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Known contents for words 0..15
        for (int i = 0; i < 16; i++) begin
            tb_write(BASE + 64'(i * 8), {$urandom, $urandom}, 8'hFF, 0, "init");
        end

        // Write then read
        tb_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, "wr_full");
        tb_read(64'h8000_0010, 0, "rd_full");
        check("rd_full.const", s_axi_r_data, 64'h1122_3344_5566_7788);

        // Partial strobe
        tb_write(64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "pre_ones");
        tb_write(64'h8000_0000, 64'h0, 8'hF0, 0, "wr_part");
        tb_read(64'h8000_0000, 0, "rd_part");
        check("rd_part.const", s_axi_r_data, 64'h0000_0000_FFFF_FFFF);

        // Out of range (index would alias word 0 if not blocked)
        tb_write(64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, "wr_oor");
        tb_read(64'h8000_0000, 0, "rd_oor_unchanged");
        tb_read(64'h8000_2000, 0, "rd_oor");
        tb_read(64'h7FFF_FFF8, 0, "rd_below");

        // Back-pressure
        tb_read(64'h8000_0018, 5, "bp_read");
        tb_write(64'h8000_2008, 64'h1, 8'h01, 5, "bp_write_oor");
        tb_write(64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'h3C, 5, "bp_write");

        // Collision: AR and AW on the same edge, W commit on R_VALID entry
        tb_write(64'h8000_0028, 64'h0, 8'hFF, 0, "col_clear");
        s_axi_aw_addr  = 64'h8000_0028;
        s_axi_ar_addr  = 64'h8000_0028;
        s_axi_aw_valid = 1'b1;
        s_axi_ar_valid = 1'b1;
        check("col.aw_ready", 64'(s_axi_aw_ready), 64'd1);
        check("col.ar_ready", 64'(s_axi_ar_ready), 64'd1);
        step();
        s_axi_aw_valid = 1'b0;
        s_axi_ar_valid = 1'b0;
        s_axi_w_data   = 64'hAAAA_AAAA_BBBB_BBBB;
        s_axi_w_strb   = 8'h0F;
        s_axi_w_valid  = 1'b1;
        check("col.w_ready", 64'(s_axi_w_ready), 64'd1);
        check("col.r_valid_early", 64'(s_axi_r_valid), 64'd0);
        step();
        s_axi_w_valid = 1'b0;
        mdl_write(64'h8000_0028, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
        check("col.r_valid", 64'(s_axi_r_valid), 64'd1);
        check("col.r_data", s_axi_r_data, 64'h0000_0000_BBBB_BBBB);
        check("col.r_resp", 64'(s_axi_r_resp), 64'd0);
        check("col.b_valid", 64'(s_axi_b_valid), 64'd1);
        s_axi_r_ready = 1'b1;
        s_axi_b_ready = 1'b1;
        step();
        s_axi_r_ready = 1'b0;
        s_axi_b_ready = 1'b0;
        check("col.r_done", 64'(s_axi_r_valid), 64'd0);
        check("col.b_done", 64'(s_axi_b_valid), 64'd0);
        tb_read(64'h8000_0028, 0, "col_readback");

        // Randomized traffic over words 0..15 plus out-of-range aliases
        for (int k = 0; k < 60; k++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 16)       addr = BASE + 64'(sel * 8);
            else if (sel < 19)  addr = BASE + 64'((DEPTH + sel - 16) * 8);
            else                addr = BASE - 64'd8;
            addr = addr + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                tb_write(addr, {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 2)), "rnd_wr");
            end else begin
                tb_read(addr, int'($urandom_range(0, 2)), "rnd_rd");
            end
        end

        // Reset in W_DATA: write must not commit
        s_axi_aw_addr  = 64'h8000_0038;
        s_axi_aw_valid = 1'b1;
        step();
        s_axi_aw_valid = 1'b0;
        check("mrst.w_ready_before", 64'(s_axi_w_ready), 64'd1);
        s_axi_w_data  = 64'h5A5A_5A5A_5A5A_5A5A;
        s_axi_w_strb  = 8'hFF;
        #2;
        rst = 1'b1;
        #1;
        check("mrst.aw_ready", 64'(s_axi_aw_ready), 64'd1);
        check("mrst.b_valid", 64'(s_axi_b_valid), 64'd0);
        check("mrst.w_ready", 64'(s_axi_w_ready), 64'd0);
        s_axi_w_valid = 1'b1;
        repeat (2) @(posedge clk);
        s_axi_w_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("mrst.r_data", s_axi_r_data, 64'd0);
        check("mrst.r_resp", 64'(s_axi_r_resp), 64'd0);
        check("mrst.b_resp", 64'(s_axi_b_resp), 64'd0);
        tb_read(64'h8000_0038, 0, "mrst_unchanged");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time bound in case a wait somewhere stalls.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_axi_lite_sram_responder
